// File: rtl/omega_egress_collector.sv
// Collects the 2*OMEGA_ARRAY_X omega output lanes into per-lane FIFOs and serialises them round-robin.
// Latency: an edge written at one clock can be presented after the next clock. Throughput is 1 edge per cycle.
// Backpressure: upstream has no ready; stall_out_o rises early, and entries that hit a full FIFO are counted as drops.
module omega_egress_collector #(
  parameter  int OMEGA_ARRAY_X   = 4,
  parameter  int OMEGA_ARRAY_Y   = 3,
  parameter  int VERTEX_ID_WIDTH = 32,
  parameter  int FIFO_DEPTH      = 8,
  localparam int L               = 2 * OMEGA_ARRAY_X,
  localparam int LW              = (L > 1) ? $clog2(L) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [L*VERTEX_ID_WIDTH-1:0] in_src_id_i,
  input  logic [L*VERTEX_ID_WIDTH-1:0] in_dst_id_i,
  input  logic [L-1:0]                 in_valid_i,
  output logic [VERTEX_ID_WIDTH-1:0]   out_src_id_o,
  output logic [VERTEX_ID_WIDTH-1:0]   out_dst_id_o,
  output logic [LW-1:0]                out_lane_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic                         stall_out_o,
  output logic                         idle_o,
  output logic                         overflow_err_o,
  output logic [15:0]                  drop_count_o
);
  localparam int W  = VERTEX_ID_WIDTH;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  // Stall while any FIFO holds more than it can still absorb from the omega levels in flight.
  localparam logic [CW-1:0] STALL_TH = CW'(FIFO_DEPTH - (OMEGA_ARRAY_Y + 2));

  logic [2*W-1:0] mem_q    [L][FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_q [L];
  logic [PW-1:0]  rd_ptr_q [L];
  logic [CW-1:0]  cnt_q    [L];
  logic [CW-1:0]  cnt_d    [L];

  logic [L-1:0]   nonempty, pop, push, drop, over;
  logic           load_en, sel_vld;
  logic [LW-1:0]  sel_lane, rr_ptr_q;
  logic [LW:0]    scan;
  logic [2*W-1:0] head_dat;
  logic [16:0]    drop_sum;

  logic [W-1:0]   out_src_q, out_dst_q;
  logic [LW-1:0]  out_lane_q;
  logic           out_valid_q, stall_q, ovf_q;
  logic [15:0]    drop_cnt_q;

  assign load_en  = ~out_valid_q | out_ready_i;
  assign head_dat = mem_q[sel_lane][rd_ptr_q[sel_lane]];
  assign drop_sum = {1'b0, drop_cnt_q} + 17'($countones(drop));

  for (genvar k = 0; k < L; k++) begin : g_lane
    assign nonempty[k] = cnt_q[k] != '0;
    assign pop[k]      = load_en & sel_vld & (sel_lane == LW'(k));
    // A full FIFO still accepts when its head leaves in the same cycle.
    assign push[k]     = in_valid_i[k] & ((cnt_q[k] < CW'(FIFO_DEPTH)) | pop[k]);
    assign drop[k]     = in_valid_i[k] & ~push[k];
    assign cnt_d[k]    = cnt_q[k] + CW'(push[k]) - CW'(pop[k]);
    assign over[k]     = cnt_d[k] > STALL_TH;

    // Per-lane occupancy and pointers; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q[k]    <= '0;
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
      end else begin
        cnt_q[k] <= cnt_d[k];
        if (push[k]) wr_ptr_q[k] <= wr_ptr_q[k] + PW'(1);
        if (pop[k])  rd_ptr_q[k] <= rd_ptr_q[k] + PW'(1);
      end
    end

    // Lane storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
      if (!rst && push[k]) begin
        mem_q[k][wr_ptr_q[k]] <= {in_src_id_i[k*W +: W], in_dst_id_i[k*W +: W]};
      end
    end
  end

  // Round-robin pick: first non-empty lane at or after rr_ptr, wrapping mod L.
  always_comb begin
    sel_vld  = 1'b0;
    sel_lane = '0;
    scan     = '0;
    for (int i = 0; i < L; i++) begin
      scan = {1'b0, rr_ptr_q} + (LW+1)'(i);
      if (scan >= (LW+1)'(L)) scan = scan - (LW+1)'(L);
      if (!sel_vld && nonempty[scan[LW-1:0]]) begin
        sel_vld  = 1'b1;
        sel_lane = scan[LW-1:0];
      end
    end
  end

  // Output register, arbitration pointer, stall flag and drop accounting.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_src_q   <= '0;
      out_dst_q   <= '0;
      out_lane_q  <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
      stall_q     <= 1'b0;
      ovf_q       <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      if (load_en) begin
        if (sel_vld) begin
          out_src_q   <= head_dat[2*W-1:W];
          out_dst_q   <= head_dat[W-1:0];
          out_lane_q  <= sel_lane;
          out_valid_q <= 1'b1;
          rr_ptr_q    <= (sel_lane == LW'(L-1)) ? '0 : sel_lane + LW'(1);
        end else begin
          out_valid_q <= 1'b0;
        end
      end
      stall_q <= |over;
      if (|drop) begin
        ovf_q      <= 1'b1;
        drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
    end
  end

  assign out_src_id_o   = out_src_q;
  assign out_dst_id_o   = out_dst_q;
  assign out_lane_o     = out_lane_q;
  assign out_valid_o    = out_valid_q;
  assign stall_out_o    = stall_q;
  assign overflow_err_o = ovf_q;
  assign drop_count_o   = drop_cnt_q;
  assign idle_o         = ~(|nonempty) & ~out_valid_q;
endmodule

// File: tb/tb_omega_egress_collector.sv
// Scoreboard bench for omega_egress_collector (L=8, W=32, depth 8, Y=3).
// Stimulus pushes expected edges; a negedge monitor pops and compares on every handshake.
module tb_omega_egress_collector;
  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] in_src, in_dst;
  logic [7:0]   in_valid;
  logic [31:0]  out_src, out_dst;
  logic [2:0]   out_lane;
  logic         out_valid, out_ready, stall_out, idle, overflow_err;
  logic [15:0]  drop_count;

  omega_egress_collector #(
    .OMEGA_ARRAY_X(4), .OMEGA_ARRAY_Y(3), .VERTEX_ID_WIDTH(32), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .rst(rst),
    .in_src_id_i(in_src), .in_dst_id_i(in_dst), .in_valid_i(in_valid),
    .out_src_id_o(out_src), .out_dst_id_o(out_dst), .out_lane_o(out_lane),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .stall_out_o(stall_out), .idle_o(idle),
    .overflow_err_o(overflow_err), .drop_count_o(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] s;
    logic [31:0] d;
    logic [2:0]  l;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive one lane for the coming edge; queue it as expected output if it should be accepted.
  task automatic drive_lane(input int k, input logic [31:0] s, input logic [31:0] d, input bit accept);
    in_valid[k]       = 1'b1;
    in_src[k*32 +: 32] = s;
    in_dst[k*32 +: 32] = d;
    if (accept) sb.push_back('{s: s, d: d, l: 3'(k)});
  endtask

  task automatic wait_idle(input string nm, input int lim);
    int n = 0;
    while (!idle && n < lim) begin
      cyc();
      n++;
    end
    chk(nm, 64'(idle), 64'd1);
  endtask

  // Monitor: every handshake must match the oldest expected edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL mon_unexpected: got lane %0d src %0h dst %0h, expected no output", out_lane, out_src, out_dst);
      end else begin
        mon_e = sb.pop_front();
        chk("mon_src",  64'(out_src),  64'(mon_e.s));
        chk("mon_dst",  64'(out_dst),  64'(mon_e.d));
        chk("mon_lane", 64'(out_lane), 64'(mon_e.l));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. Reset with all lanes valid: nothing may be stored.
    rst = 1'b1; out_ready = 1'b1; in_valid = 8'hFF;
    in_src = {8{32'hDEAD_BEEF}}; in_dst = {8{32'h1234_5678}};
    repeat (3) cyc();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_src",   64'(out_src),   64'd0);
    chk("rst_dst",   64'(out_dst),   64'd0);
    chk("rst_lane",  64'(out_lane),  64'd0);
    chk("rst_stall", 64'(stall_out), 64'd0);
    chk("rst_idle",  64'(idle),      64'd1);
    chk("rst_ovf",   64'(overflow_err), 64'd0);
    chk("rst_drop",  64'(drop_count),   64'd0);
    rst = 1'b0; in_valid = '0;
    cyc();
    chk("rst_nowrite_idle", 64'(idle), 64'd1);

    // 2. Lanes 0 and 7 together: lane0 first, then lane7, then idle.
    drive_lane(0, 32'd5, 32'd9, 1'b1);
    drive_lane(7, 32'd2, 32'd4, 1'b1);
    cyc();
    in_valid = '0;
    chk("t2_lat0_valid", 64'(out_valid), 64'd0);
    cyc();
    chk("t2_first_valid", 64'(out_valid), 64'd1);
    chk("t2_first_lane",  64'(out_lane),  64'd0);
    cyc();
    chk("t2_second_lane", 64'(out_lane),  64'd7);
    cyc();
    chk("t2_done_valid", 64'(out_valid), 64'd0);
    chk("t2_done_idle",  64'(idle),      64'd1);

    // 3. Lane0 with consumer blocked. The first edge sits in the output register,
    //    so FIFO0 reaches count 4 (stall threshold) only on the fifth write.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_lane(0, 32'd100 + 32'(i), 32'd200 + 32'(i), 1'b1);
      cyc();
      if (i == 3) chk("t3_stall_cnt3", 64'(stall_out), 64'd0);
    end
    in_valid = '0;
    chk("t3_stall_cnt4", 64'(stall_out), 64'd1);
    out_ready = 1'b1;
    cyc();
    chk("t3_stall_release", 64'(stall_out), 64'd0);
    wait_idle("t3_drain_idle", 20);

    // 4. Ten writes into blocked lane0: 1 in output reg + 8 in FIFO, 10th dropped.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_lane(0, 32'd300 + 32'(i), 32'd400 + 32'(i), i < 9);
      cyc();
      if (i == 8) chk("t4_drop_before_full", 64'(drop_count), 64'd0);
    end
    in_valid = '0;
    chk("t4_ovf",  64'(overflow_err), 64'd1);
    chk("t4_drop", 64'(drop_count),   64'd1);
    out_ready = 1'b1;
    wait_idle("t4_drain_idle", 30);
    chk("t4_sb_empty", 64'(sb.size()), 64'd0);

    // Reset so the round-robin pointer starts at lane 0 again.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t5_rst_ovf", 64'(overflow_err), 64'd0);

    // 5. All lanes once: lanes 0..7 on consecutive cycles.
    for (int k = 0; k < 8; k++) drive_lane(k, 32'h10 + 32'(k), 32'h20 + 32'(k), 1'b1);
    cyc();
    in_valid = '0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("t5_rr_valid", 64'(out_valid), 64'd1);
      chk("t5_rr_lane",  64'(out_lane),  64'(k));
    end
    cyc();
    chk("t5_done_idle", 64'(idle), 64'd1);

    // 6. Fill FIFO0, then pop and write lane0 in the same cycle: write must be accepted.
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive_lane(0, 32'd500 + 32'(i), 32'd600 + 32'(i), 1'b1);
      cyc();
    end
    out_ready = 1'b1;
    drive_lane(0, 32'd777, 32'd888, 1'b1);
    cyc();
    in_valid = '0;
    chk("t6_drop_unchanged", 64'(drop_count),   64'd0);
    chk("t6_no_ovf",         64'(overflow_err), 64'd0);
    chk("t6_stall_full",     64'(stall_out),    64'd1);
    cyc();
    cyc();
    // Reset mid-drain discards everything still queued.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    sb.delete();
    chk("t6_rst_idle",  64'(idle),      64'd1);
    chk("t6_rst_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_stall", 64'(stall_out), 64'd0);
    repeat (3) cyc();
    chk("t6_post_idle", 64'(idle), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
